mc_fork_stage: RTL and testbench

//  Multicast fork stage sitting directly downstream of multicast route compute.

---
 rtl/mc_fork_stage.sv | 162 ++++++++++++++++
 tb/tb_mc_fork_stage.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_fork_stage.sv
// mc_fork_stage: multicast fork stage placed directly after multicast route
// compute. Holds one flit with its preferred-port vector and offers a copy to
// every requested output port. Each output grant retires its port bit, and the
// slot frees once every copy has been granted.
//
// A new flit may be accepted in the same cycle as the final grant, so
// back-to-back flits pass through with no idle bubble.
//
// Optional feature macro: MC_STALL_MON_EN
//   defined     -> 4-bit saturating stall counter drives a registered 'starved'
//   not defined -> no counter, 'starved' tied low
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | slot empty, ready for a new flit
// FORK  | flit held, pending != 0, copies still owed to some ports

module mc_fork_stage #(
   parameter int FLIT_WIDTH  = 64,
   parameter int DST_WIDTH   = 16,
   parameter int NUM_PORT    = 5,
   parameter int STALL_LIMIT = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [FLIT_WIDTH-1:0] in_flit,
   input  logic [DST_WIDTH-1:0]  in_dst,
   input  logic [NUM_PORT-1:0]   in_ppv,
   input  logic                  in_ltb,
   input  logic                  in_rtb,
   output logic [NUM_PORT-1:0]   out_req,
   input  logic [NUM_PORT-1:0]   out_gnt,
   output logic [FLIT_WIDTH-1:0] out_flit,
   output logic [DST_WIDTH-1:0]  out_dst,
   output logic                  out_ltb,
   output logic                  out_rtb,
   output logic                  drop_pulse,
   output logic                  starved
);

   // The stall counter is 4 bits wide and saturates at 15, so a larger limit
   // could never be reached and a limit below 1 would flag starvation at once.
   if (STALL_LIMIT < 1 || STALL_LIMIT > 15) begin : gBadStallLimit
      $error("mc_fork_stage: STALL_LIMIT must be within 1..15");
   end

   typedef enum logic {
      IDLE = 1'b0,
      FORK = 1'b1
   } stateT;

   stateT                 state;
   stateT                 stateNext;
   logic [NUM_PORT-1:0]   pending;
   logic [NUM_PORT-1:0]   effGnt;
   logic                  isFork;
   logic                  last;
   logic                  readyInt;
   logic                  accept;
   logic                  zeroPpv;

   // Grant bits for ports that were never requested are simply ignored.
   assign effGnt  = out_gnt & pending;
   assign zeroPpv = (in_ppv == '0);

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Next-state logic: an accept always wins, since it can overlap the last grant
   always_comb begin
      stateNext = state;
      if (accept) begin
         stateNext = zeroPpv ? IDLE : FORK;
      end else if (last) begin
         stateNext = IDLE;
      end
   end

   // FSM outputs: last-grant detect, combinational ready and accept handshake
   always_comb begin
      isFork   = (state == FORK);
      last     = isFork && ((pending & ~out_gnt) == '0);
      readyInt = !isFork || last;
      accept   = in_valid && readyInt;
   end

   assign in_ready = readyInt;
   assign out_req  = pending;

   // Pending mask: loaded on accept, otherwise each granted bit is retired
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending <= '0;
      end else if (accept) begin
         pending <= in_ppv;
      end else if (isFork) begin
         pending <= pending & ~effGnt;
      end
   end

   // Held flit and routing bits; these change only when a new flit is taken
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_flit <= '0;
         out_dst  <= '0;
         out_ltb  <= 1'b0;
         out_rtb  <= 1'b0;
      end else if (accept) begin
         out_flit <= in_flit;
         out_dst  <= in_dst;
         out_ltb  <= in_ltb;
         out_rtb  <= in_rtb;
      end
   end

   // A flit with no preferred port is consumed and flagged for one cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         drop_pulse <= 1'b0;
      end else begin
         drop_pulse <= accept && zeroPpv;
      end
   end

`ifdef MC_STALL_MON_EN
   logic [3:0] stallCnt;
   logic [3:0] stallCntNext;
   logic       starvedReg;

   // Count FORK cycles with no useful grant; any grant or leaving FORK clears it
   always_comb begin
      stallCntNext = '0;
      if (isFork && (stateNext == FORK) && (effGnt == '0)) begin
         stallCntNext = (stallCnt == 4'hF) ? stallCnt : stallCnt + 4'd1;
      end
   end

   // starved follows the counter value being loaded, so both update together
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stallCnt   <= '0;
         starvedReg <= 1'b0;
      end else begin
         stallCnt   <= stallCntNext;
         starvedReg <= (int'(stallCntNext) >= STALL_LIMIT);
      end
   end

   assign starved = starvedReg;
`else
   assign starved = 1'b0;
`endif

endmodule

// File: tb/tb_mc_fork_stage.sv
// Bench for mc_fork_stage: directed scenarios followed by random traffic, all
// checked against a per-flit reference model (pending copies of the held flit).

module tb_mc_fork_stage;

   localparam int FW = 64;
   localparam int DW = 16;
   localparam int NP = 5;
   localparam int LIMIT = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [FW-1:0] in_flit;
   logic [DW-1:0] in_dst;
   logic [NP-1:0] in_ppv;
   logic          in_ltb;
   logic          in_rtb;
   logic [NP-1:0] out_req;
   logic [NP-1:0] out_gnt;
   logic [FW-1:0] out_flit;
   logic [DW-1:0] out_dst;
   logic          out_ltb;
   logic          out_rtb;
   logic          drop_pulse;
   logic          starved;

   always #5 clk = ~clk;

   mc_fork_stage #(
      .FLIT_WIDTH (FW),
      .DST_WIDTH  (DW),
      .NUM_PORT   (NP),
      .STALL_LIMIT(LIMIT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_flit   (in_flit),
      .in_dst    (in_dst),
      .in_ppv    (in_ppv),
      .in_ltb    (in_ltb),
      .in_rtb    (in_rtb),
      .out_req   (out_req),
      .out_gnt   (out_gnt),
      .out_flit  (out_flit),
      .out_dst   (out_dst),
      .out_ltb   (out_ltb),
      .out_rtb   (out_rtb),
      .drop_pulse(drop_pulse),
      .starved   (starved)
   );

   int nChecks = 0;
   int nPass   = 0;
   int nFail   = 0;

   // Reference model: copies still owed for the held flit, plus its data
   logic [NP-1:0] mOwed;
   logic [FW-1:0] mFlit;
   logic [DW-1:0] mDst;
   bit            mLtb;
   bit            mRtb;
   bit            mDrop;
   int            mIdleGrantRun;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nChecks++;
      assert (obs === exp) nPass++;
      else begin
         nFail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      mOwed = '0;
      mFlit = '0;
      mDst = '0;
      mLtb = 0;
      mRtb = 0;
      mDrop = 0;
      mIdleGrantRun = 0;
   endtask

   // Slot can take a flit if nothing is owed or every owed copy is granted now
   function automatic bit modelReady(input logic [NP-1:0] gnt);
      return (mOwed == '0) || ((mOwed & ~gnt) == '0);
   endfunction

   task automatic modelClock(input bit v, input logic [NP-1:0] ppv, input logic [NP-1:0] gnt,
                             input logic [FW-1:0] flit, input logic [DW-1:0] dst,
                             input bit l, input bit r);
      bit holding;
      bit usefulGrant;
      holding = (mOwed != '0);
      usefulGrant = ((gnt & mOwed) != '0);
      if (holding && !usefulGrant) mIdleGrantRun = (mIdleGrantRun < 15) ? mIdleGrantRun + 1 : 15;
      else mIdleGrantRun = 0;
      if (v && modelReady(gnt)) begin
         mOwed = ppv;
         mFlit = flit;
         mDst = dst;
         mLtb = l;
         mRtb = r;
         mDrop = (ppv == '0);
      end else begin
         mOwed = mOwed & ~gnt;
         mDrop = 0;
      end
   endtask

   function automatic bit expStarved();
`ifdef MC_STALL_MON_EN
      return (mIdleGrantRun >= LIMIT);
`else
      return 1'b0;
`endif
   endfunction

   task automatic checkOutputs();
      check("out_req",    64'(out_req),    64'(mOwed));
      check("out_flit",   64'(out_flit),   64'(mFlit));
      check("out_dst",    64'(out_dst),    64'(mDst));
      check("out_ltb",    64'(out_ltb),    64'(mLtb));
      check("out_rtb",    64'(out_rtb),    64'(mRtb));
      check("drop_pulse", 64'(drop_pulse), 64'(mDrop));
      check("starved",    64'(starved),    64'(expStarved()));
   endtask

   // One clock: drive after the falling edge, check ready, clock, check outputs
   task automatic step(input bit v, input logic [NP-1:0] ppv, input logic [NP-1:0] gnt,
                       input logic [FW-1:0] flit, input logic [DW-1:0] dst,
                       input bit l, input bit r);
      in_valid = v;
      in_ppv = ppv;
      out_gnt = gnt;
      in_flit = flit;
      in_dst = dst;
      in_ltb = l;
      in_rtb = r;
      #1;
      check("in_ready", 64'(in_ready), 64'(modelReady(gnt)));
      @(posedge clk);
      modelClock(v, ppv, gnt, flit, dst, l, r);
      @(negedge clk);
      checkOutputs();
   endtask

   task automatic idle(input logic [NP-1:0] gnt);
      step(1'b0, '0, gnt, '0, '0, 1'b0, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [FW-1:0] flitA;
      logic [FW-1:0] flitB;
      logic [NP-1:0] rPpv;
      logic [NP-1:0] rGnt;
      bit            rValid;

      reset = 1'b1;
      in_valid = 1'b0;
      in_ppv = '0;
      out_gnt = '0;
      in_flit = '0;
      in_dst = '0;
      in_ltb = 1'b0;
      in_rtb = 1'b0;
      modelReset();
      @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'(1'b1));
      checkOutputs();
      reset = 1'b0;

      // Unicast east
      flitA = 64'hA5A5_0001_DEAD_BEEF;
      step(1'b1, 5'b00010, '0, flitA, 16'h0042, 1'b1, 1'b0);
      check("uni_req_n1", 64'(out_req), 64'(5'b00010));
      check("uni_flit", 64'(out_flit), flitA);
      idle(5'b00010);
      check("uni_req_n2", 64'(out_req), 64'(5'b00000));
      idle('0);
      check("uni_idle_ready", 64'(in_ready), 64'(1'b1));

      // Multicast N, S, Local granted one per cycle
      step(1'b1, 5'b10101, '0, 64'h1111_2222_3333_4444, 16'h8001, 1'b0, 1'b1);
      check("mc_req0", 64'(out_req), 64'(5'b10101));
      idle(5'b00001);
      check("mc_req1", 64'(out_req), 64'(5'b10100));
      idle(5'b00100);
      check("mc_req2", 64'(out_req), 64'(5'b10000));
      out_gnt = 5'b10000;
      in_valid = 1'b0;
      #1;
      check("mc_ready_local", 64'(in_ready), 64'(1'b1));
      idle(5'b10000);
      check("mc_req3", 64'(out_req), 64'(5'b00000));

      // Back-to-back: next flit accepted on the final grant
      flitB = 64'hB0B0_B0B0_0000_0002;
      step(1'b1, 5'b00011, '0, 64'h0123_4567_89AB_CDEF, 16'h0003, 1'b0, 1'b0);
      step(1'b1, 5'b01000, 5'b00011, flitB, 16'h0400, 1'b1, 1'b1);
      check("b2b_req", 64'(out_req), 64'(5'b01000));
      check("b2b_flit", 64'(out_flit), flitB);
      idle(5'b01000);

      // Zero preferred-port vector is dropped
      step(1'b1, 5'b00000, '0, 64'hDEAD_0000_0000_0000, 16'hFFFF, 1'b1, 1'b0);
      check("zero_drop", 64'(drop_pulse), 64'(1'b1));
      check("zero_req", 64'(out_req), 64'(5'b00000));
      idle('0);
      check("zero_drop_off", 64'(drop_pulse), 64'(1'b0));

      // Stray grants and back-pressure while forking
      step(1'b1, 5'b00100, '0, 64'h5555_5555_5555_5555, 16'h0010, 1'b0, 1'b0);
      step(1'b1, 5'b11111, 5'b01011, 64'h6666_6666_6666_6666, 16'h0020, 1'b1, 1'b1);
      check("stray_req", 64'(out_req), 64'(5'b00100));
      check("stray_flit", 64'(out_flit), 64'h5555_5555_5555_5555);
      idle(5'b00100);

      // Starvation: no grants for a long stretch, then one grant
      step(1'b1, 5'b00001, '0, 64'h0000_0000_0000_0777, 16'h0001, 1'b0, 1'b0);
      for (int i = 0; i < LIMIT - 1; i++) idle('0);
      check("starve_before", 64'(starved), 64'(1'b0));
      idle('0);
`ifdef MC_STALL_MON_EN
      check("starve_set", 64'(starved), 64'(1'b1));
`else
      check("starve_tied", 64'(starved), 64'(1'b0));
`endif
      for (int i = 0; i < 10; i++) idle('0);
      idle(5'b00001);
      check("starve_clear", 64'(starved), 64'(1'b0));
      check("starve_req", 64'(out_req), 64'(5'b00000));

      // Asynchronous reset in the middle of a fork
      step(1'b1, 5'b01100, '0, 64'hCAFE_F00D_0000_0001, 16'h1234, 1'b1, 1'b1);
      check("arst_pre_req", 64'(out_req), 64'(5'b01100));
      in_valid = 1'b0;
      out_gnt = '0;
      #2;
      reset = 1'b1;
      #1;
      check("arst_req", 64'(out_req), 64'(5'b00000));
      check("arst_ready", 64'(in_ready), 64'(1'b1));
      check("arst_flit", 64'(out_flit), 64'h0);
      modelReset();
      @(negedge clk);
      reset = 1'b0;
      checkOutputs();

      // Random traffic against the model
      for (int i = 0; i < 1500; i++) begin
         rValid = ($urandom_range(0, 3) != 0);
         rPpv = ($urandom_range(0, 15) == 0) ? 5'b00000 : 5'($urandom);
         rGnt = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'b00000;
         step(rValid, rPpv, rGnt, {$urandom, $urandom}, 16'($urandom),
              1'($urandom), 1'($urandom));
      end

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
